// File: rtl/ship_map_display_if.sv
// ship_map_display_if: map/cursor inputs and multiplexed 7-segment drive for the battle-field display
interface ship_map_display_if;
    logic        phase;
    logic [27:0] pships;
    logic [27:0] hits;
    logic [3:0]  cur_an;
    logic [7:0]  cur_seg;
    logic [3:0]  an;
    logic [7:0]  seg;

    modport master (
        output phase, pships, hits, cur_an, cur_seg,
        input  an, seg
    );

    modport slave (
        input  phase, pships, hits, cur_an, cur_seg,
        output an, seg
    );
endinterface

// File: rtl/ship_map_display.sv
// ship_map_display: scans the 28-bit ship/hit map onto four active-low 7-segment digits with a blinking cursor overlay
module ship_map_display #(
    parameter int SCAN_DIV  = 1,
    parameter int BLINK_DIV = 200
) (
    input  logic               clk,
    input  logic               rst_n,
    ship_map_display_if.slave  bus
);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;

    logic [SW-1:0] r_scan_cnt;
    logic [BW-1:0] r_blink_cnt;
    logic [1:0]    r_d;
    logic          r_blink;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_scan_wrap;
    logic          w_blink_wrap;
    logic          w_blink_next;
    logic [3:0]    w_an_next;
    logic [27:0]   w_map;
    logic [6:0]    w_field;
    logic [6:0]    w_base;
    logic [6:0]    w_mask;
    logic          w_cur_valid;
    logic          w_cur_hit;
    logic [7:0]    w_seg_next;

    assign w_scan_wrap  = r_scan_cnt == SW'(SCAN_DIV - 1);
    assign w_blink_wrap = r_blink_cnt == BW'(BLINK_DIV - 1);
    assign w_blink_next = w_blink_wrap ? ~r_blink : r_blink;

    // Digit driven on this edge is the current scan index; the index advances behind it
    assign w_an_next = ~(4'b0001 << r_d);
    assign w_map     = bus.phase ? bus.hits : bus.pships;
    assign w_field   = 7'(w_map >> (7 * r_d));

    // Board wiring of map bits onto segments a..g, active-low
    assign w_base = ~{w_field[5], w_field[6], w_field[2], w_field[3],
                      w_field[4], w_field[0], w_field[1]};

    // A cursor with zero or several active lines is treated as absent; cur_seg[7] is ignored
    assign w_cur_valid = $onehot(~bus.cur_an) && $onehot(~bus.cur_seg[6:0]);
    assign w_cur_hit   = w_cur_valid && (bus.cur_an == w_an_next);
    assign w_mask      = ~bus.cur_seg[6:0];

    // Cursor segment follows the new blink phase; decimal point marks the battle cursor
    assign w_seg_next = {~(w_cur_hit & bus.phase),
                         w_cur_hit ? (w_blink_next ? (w_base & ~w_mask) : (w_base | w_mask)) : w_base};

    // Scan and blink timebases
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_cnt  <= '0;
            r_d         <= 2'd0;
            r_blink_cnt <= '0;
            r_blink     <= 1'b0;
        end else begin
            r_scan_cnt  <= w_scan_wrap ? '0 : r_scan_cnt + 1'b1;
            r_d         <= w_scan_wrap ? r_d + 2'd1 : r_d;
            r_blink_cnt <= w_blink_wrap ? '0 : r_blink_cnt + 1'b1;
            r_blink     <= w_blink_next;
        end
    end

    // Digit enable and segment data registered together so they never disagree
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus.an  = r_an;
    assign bus.seg = r_seg;
endmodule

// File: tb/tb_ship_map_display.sv
// tb_ship_map_display: directed vectors checked through a scoreboard queue of expected {an,seg}
module tb_ship_map_display;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    logic [11:0] exp_q[$];

    ship_map_display_if bus();

    ship_map_display #(.SCAN_DIV(1), .BLINK_DIV(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Monitor: every non-blank digit presented by the DUT must match the next expected entry
    always @(negedge clk) begin
        if (rst_n && bus.an !== 4'hF) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output: got an=%b seg=%b, none expected", bus.an, bus.seg);
            end else begin
                logic [11:0] e;
                e = exp_q.pop_front();
                if ({bus.an, bus.seg} !== e) begin
                    n_err++;
                    $display("FAIL scan_digit: got an=%b seg=%b, expected an=%b seg=%b",
                             bus.an, bus.seg, e[11:8], e[7:0]);
                end
            end
        end
    end

    task automatic set_in(input logic ph, input logic [27:0] ps, input logic [27:0] ht,
                          input logic [3:0] ca, input logic [7:0] cs);
        bus.phase = ph; bus.pships = ps; bus.hits = ht; bus.cur_an = ca; bus.cur_seg = cs;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] s);
        exp_q.push_back({a, s});
    endtask

    task automatic check_drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d expected outputs not seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run(input int n, input string name);
        #1 rst_n = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        #1;
        check_drained(name);
    endtask

    task automatic check_blank(input string name);
        n_cmp++;
        if (bus.an !== 4'hF || bus.seg !== 8'hFF) begin
            n_err++;
            $display("FAIL %s: got an=%b seg=%h, expected an=1111 seg=ff", name, bus.an, bus.seg);
        end
    endtask

    initial begin
        set_in(1'b0, 28'h0, 28'h0, 4'hF, 8'hFF);
        reset_dut();
        check_blank("reset_state");

        // Empty map, no cursor: plain scan sequence
        push(4'hE, 8'hFF); push(4'hD, 8'hFF); push(4'hB, 8'hFF); push(4'h7, 8'hFF); push(4'hE, 8'hFF);
        run(5, "scan_blank");

        // Bit 1 lights segment 0 of field 0
        reset_dut();
        set_in(1'b0, 28'h0000002, 28'h0, 4'hF, 8'hFF);
        push(4'hE, 8'hFE); push(4'hD, 8'hFF); push(4'hB, 8'hFF); push(4'h7, 8'hFF);
        run(4, "bit1");

        // Bit 27 lights segment 5 of field 3
        reset_dut();
        set_in(1'b0, 28'h8000000, 28'h0, 4'hF, 8'hFF);
        push(4'hE, 8'hFF); push(4'hD, 8'hFF); push(4'hB, 8'hFF); push(4'h7, 8'hDF);
        run(4, "bit27");

        // Cursor on field 1 segment 2 blinking with half-period 4; cur_seg[7]=0 is ignored
        reset_dut();
        set_in(1'b0, 28'h0, 28'h0, 4'b1101, 8'h7B);
        for (int k = 0; k < 4; k++) begin
            push(4'hE, 8'hFF);
            push(4'hD, k[0] ? 8'hFB : 8'hFF);
            push(4'hB, 8'hFF);
            push(4'h7, 8'hFF);
        end
        run(16, "blink");

        // Battle phase: hits shown, ships hidden, decimal point marks cursor digit
        reset_dut();
        set_in(1'b1, 28'hFFFFFFF, 28'h0000080, 4'b1110, 8'hFE);
        push(4'hE, 8'h7F); push(4'hD, 8'hFD); push(4'hB, 8'hFF); push(4'h7, 8'hFF);
        push(4'hE, 8'h7E); push(4'hD, 8'hFD); push(4'hB, 8'hFF); push(4'h7, 8'hFF);
        run(8, "battle");

        // Two active digit lines: cursor invalid, no overlay and no decimal point
        reset_dut();
        set_in(1'b1, 28'h0, 28'h0, 4'b1100, 8'hFE);
        for (int k = 0; k < 8; k++) push(4'(~(4'b0001 << (k % 4))), 8'hFF);
        run(8, "invalid_cursor");

        // Two active segment lines: cursor invalid
        reset_dut();
        set_in(1'b0, 28'h0, 28'h0, 4'b1110, 8'hFC);
        for (int k = 0; k < 8; k++) push(4'(~(4'b0001 << (k % 4))), 8'hFF);
        run(8, "invalid_seg");

        // Asynchronous reset mid-scan at d=2, then restart from digit 0
        reset_dut();
        set_in(1'b0, 28'h0000002, 28'h0, 4'hF, 8'hFF);
        push(4'hE, 8'hFE); push(4'hD, 8'hFF); push(4'hB, 8'hFF);
        run(3, "pre_reset");
        #2 rst_n = 1'b0;
        #1 check_blank("async_reset");
        @(negedge clk);
        push(4'hE, 8'hFE); push(4'hD, 8'hFF);
        run(2, "restart");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
